// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch unit: FSM state encoding,
// instruction field positions, the default reset PC and the branch-offset
// helper used by next-PC selection.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   // FSM state encoding. FAULT is only reachable when IFETCH_TIMEOUT_EN is set.
   localparam logic [1:0] RESET_S = 2'd0;
   localparam logic [1:0] FETCH   = 2'd1;
   localparam logic [1:0] EXEC    = 2'd2;
   localparam logic [1:0] FAULT   = 2'd3;

   // Instruction field positions
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sign-extended 16-bit immediate scaled to a byte offset (imm << 2).
   function automatic logic signed [31:0] branch_offset(input logic signed [15:0] imm);
      logic signed [31:0] ext;
      ext = {{16{imm[15]}}, imm};
      return ext <<< 2;
   endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Purely combinational next-PC selection. Priority: jump, then branch, then
// sequential. All additions wrap modulo 2^32.
//   pc        in   current PC
//   instr     in   held instruction word
//   pcsrc     in   branch taken
//   jump      in   jump taken
//   pc_plus4  out  PC + 4
//   pc_target out  selected next PC
// -----------------------------------------------------------------------------
module pc_next
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_target
);

   // The opcode field does not take part in target selection.
   logic unused_opcode;
   assign unused_opcode = ^instr[OP_MSB:OP_LSB];

   always_comb begin
      pc_plus4 = pc + 32'd4;
      if (jump) begin
         // Region bits come from PC+4, not PC.
         pc_target = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (pcsrc) begin
         pc_target = pc_plus4 + $unsigned(branch_offset(instr[15:0]));
      end else begin
         pc_target = pc_plus4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: requests a word at PC, holds it in Instr while the
// controller executes it, then advances PC (jump / branch / sequential).
// Optional feature macro: IFETCH_TIMEOUT_EN -- bounds the wait for imem_ack to
// TIMEOUT_CYCLES and parks in a sticky FAULT state on expiry. Without it the
// fetch waits indefinitely and fetch_fault is tied low.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   fetch request / word address (= PC)
//   imem_ack, imem_rdata  read-data strobe / instruction word
//   stall                 hold the current instruction in EXEC
//   PCSrc, Jump           controller branch / jump decisions
//   Instr, Opcode, Funct  held instruction and its decoded fields
//   PC, PCPlus4           held instruction address and PC+4
//   instr_valid           Instr is valid for the controller (EXEC)
//   fetch_fault           sticky fetch timeout flag
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        PCSrc,
   input  logic        Jump,
   output logic [31:0] Instr,
   output logic [5:0]  Opcode,
   output logic [5:0]  Funct,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        instr_valid,
   output logic        fetch_fault
);

   logic [1:0]  state;
   logic [31:0] pc_target;
   logic        tmo_hit;

   pc_next u_pc_next (
      .pc        (PC),
      .instr     (Instr),
      .pcsrc     (PCSrc),
      .jump      (Jump),
      .pc_plus4  (PCPlus4),
      .pc_target (pc_target)
   );

   assign Opcode      = Instr[OP_MSB:OP_LSB];
   assign Funct       = Instr[FUNCT_MSB:FUNCT_LSB];
   assign imem_addr   = PC;
   // Decoded from state so an asynchronous reset drops the request at once.
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);

`ifdef IFETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;

   assign tmo_hit     = (state == FETCH) && !imem_ack &&
                        ((tmo_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
   assign fetch_fault = (state == FAULT);

   // Held at zero outside FETCH, so every FETCH entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state != FETCH) begin
         tmo_cnt <= '0;
      end else if (!imem_ack) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign tmo_hit     = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_S;
         PC    <= RESET_PC;
         Instr <= '0;
      end else begin
         case (state)
            RESET_S: state <= FETCH;
            FETCH: begin
               if (imem_ack) begin
                  Instr <= imem_rdata;
                  state <= EXEC;
               end else if (tmo_hit) begin
                  state <= FAULT;
               end
            end
            EXEC: begin
               // Stall freezes PC/Instr; branch/jump inputs are don't-care then.
               if (!stall) begin
                  PC    <= pc_target;
                  state <= FETCH;
               end
            end
            default: state <= state;  // FAULT: left only by reset
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: a vector table of instructions with
// branch/jump decisions and expected PCs, a scoreboard queue of expected fetch
// addresses, and hand-written stall, wait/timeout and reset sequences.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        PCSrc;
   logic        Jump;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic [5:0]  Funct;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        instr_valid;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] rdata;
      logic        pcsrc;
      logic        jump;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[11];

   instr_fetch #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .PCSrc       (PCSrc),
      .Jump        (Jump),
      .Instr       (Instr),
      .Opcode      (Opcode),
      .Funct       (Funct),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .instr_valid (instr_valid),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expects the DUT in FETCH at the address at the head of the scoreboard.
   task automatic check_fetch(input string name);
      chk({name, "_req"}, imem_req, 1'b1);
      chk({name, "_valid"}, instr_valid, 1'b0);
      chk({name, "_fault"}, fetch_fault, 1'b0);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_addr: got %h expected <empty scoreboard>", name, imem_addr);
      end else begin
         chk({name, "_addr"}, imem_addr, exp_q.pop_front());
      end
   endtask

   // One instruction: same-cycle ack in FETCH, check EXEC, apply decision.
   task automatic run_vec(input vec_t v, input string name);
      check_fetch(name);
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk({name, "_ivalid"}, instr_valid, 1'b1);
      chk({name, "_exreq"}, imem_req, 1'b0);
      chk({name, "_instr"}, Instr, v.rdata);
      chk({name, "_opcode"}, {26'b0, Opcode}, {26'b0, v.rdata[31:26]});
      chk({name, "_funct"}, {26'b0, Funct}, {26'b0, v.rdata[5:0]});
      chk({name, "_pc"}, PC, v.exp_pc);
      chk({name, "_pcplus4"}, PCPlus4, v.exp_pc + 32'd4);
      PCSrc = v.pcsrc;
      Jump  = v.jump;
      stall = 1'b0;
      exp_q.push_back(v.exp_next);
      step();
      PCSrc = 1'b0;
      Jump  = 1'b0;
   endtask

   initial begin
      vec_t v;
      // rdata, pcsrc, jump, pc in EXEC, next fetch address
      vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004}; // addi, sequential
      vecs[1]  = '{32'h0800_0010, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0040}; // jump 0x40
      vecs[2]  = '{32'h1000_0003, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0050}; // branch +3 words
      vecs[3]  = '{32'h0800_0040, 1'b0, 1'b1, 32'h0000_0050, 32'h0000_0100}; // jump 0x100
      vecs[4]  = '{32'h0800_0010, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040}; // jump beats branch
      vecs[5]  = '{32'h1000_FFFE, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_003C}; // branch -2 words
      vecs[6]  = '{32'h1000_FFFE, 1'b0, 1'b0, 32'h0000_003C, 32'h0000_0040}; // not taken
      vecs[7]  = '{32'h1000_FFEE, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC}; // branch wraps down
      vecs[8]  = '{32'h2008_0005, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000}; // PC+4 wraps
      vecs[9]  = '{32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h0FFF_FFFC}; // max jump index
      vecs[10] = '{32'h0800_0001, 1'b0, 1'b1, 32'h0FFF_FFFC, 32'h1000_0004}; // region from PC+4

      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      stall      = 1'b0;
      PCSrc      = 1'b0;
      Jump       = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_fault", fetch_fault, 1'b0);

      rst_n = 1'b1;
      exp_q.push_back(32'h0000_0000);
      step();

      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         run_vec(v, $sformatf("vec%0d", i));
      end

      // Stall for 3 EXEC cycles with PCSrc/Jump toggling and a stray ack.
      check_fetch("stall_f");
      imem_ack   = 1'b1;
      imem_rdata = 32'h1000_0003;
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         PCSrc      = i[0];
         Jump       = ~i[0];
         imem_ack   = 1'b1;
         imem_rdata = 32'h1234_5678;
         step();
         chk($sformatf("stall%0d_pc", i), PC, 32'h1000_0004);
         chk($sformatf("stall%0d_instr", i), Instr, 32'h1000_0003);
         chk($sformatf("stall%0d_valid", i), instr_valid, 1'b1);
         chk($sformatf("stall%0d_req", i), imem_req, 1'b0);
      end
      stall    = 1'b0;
      PCSrc    = 1'b0;
      Jump     = 1'b0;
      imem_ack = 1'b0;
      exp_q.push_back(32'h1000_0008);
      step();
      check_fetch("unstall");

      // No ack: the request must persist (or time out with the feature on).
`ifdef IFETCH_TIMEOUT_EN
      repeat (15) step();
      chk("tmo_pre_req", imem_req, 1'b1);
      chk("tmo_pre_fault", fetch_fault, 1'b0);
      step();
      chk("tmo_fault", fetch_fault, 1'b1);
      chk("tmo_req", imem_req, 1'b0);
      chk("tmo_valid", instr_valid, 1'b0);
      repeat (3) step();
      chk("tmo_sticky", fetch_fault, 1'b1);
`else
      repeat (20) step();
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, 32'h1000_0008);
      chk("wait_fault", fetch_fault, 1'b0);
`endif

      // Asynchronous reset with an ack arriving during and just after reset.
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_req", imem_req, 1'b0);
      chk("arst_fault", fetch_fault, 1'b0);
      chk("arst_pc", PC, 32'h0);
      chk("arst_instr", Instr, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("late_ack_instr", Instr, 32'h0);
      chk("late_ack_valid", instr_valid, 1'b0);
      imem_ack = 1'b0;
      exp_q.push_back(32'h0000_0000);
      v = '{32'h0000_0020, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
      run_vec(v, "restart");
      check_fetch("restart_next");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
